// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - N-master AXI read arbiter with round-robin AR, ID-tagged R routing and per-master burst limits
// Outgoing ARID carries the winner index in its low bits; R beats are routed back by that tag.
module axi_read_arbiter #(
  parameter int N_MASTERS       = 2,
  parameter int ID_WIDTH        = 13,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W          = $clog2(N_MASTERS),
  localparam int MID_WIDTH      = ID_WIDTH - IDX_W
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_MASTERS*MID_WIDTH-1:0]  s_axi_arid,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [N_MASTERS*8-1:0]          s_axi_arlen,
  input  logic [N_MASTERS*3-1:0]          s_axi_arsize,
  input  logic [N_MASTERS*2-1:0]          s_axi_arburst,
  input  logic [N_MASTERS-1:0]            s_axi_arlock,
  input  logic [N_MASTERS*4-1:0]          s_axi_arcache,
  input  logic [N_MASTERS*3-1:0]          s_axi_arprot,
  input  logic [N_MASTERS-1:0]            s_axi_arvalid,
  output logic [N_MASTERS-1:0]            s_axi_arready,
  output logic [N_MASTERS*MID_WIDTH-1:0]  s_axi_rid,
  output logic [N_MASTERS*DATA_WIDTH-1:0] s_axi_rdata,
  output logic [N_MASTERS*2-1:0]          s_axi_rresp,
  output logic [N_MASTERS-1:0]            s_axi_rlast,
  output logic [N_MASTERS-1:0]            s_axi_rvalid,
  input  logic [N_MASTERS-1:0]            s_axi_rready,
  output logic [ID_WIDTH-1:0]             m_axi_arid,
  output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
  output logic [7:0]                      m_axi_arlen,
  output logic [2:0]                      m_axi_arsize,
  output logic [1:0]                      m_axi_arburst,
  output logic                            m_axi_arlock,
  output logic [3:0]                      m_axi_arcache,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [ID_WIDTH-1:0]             m_axi_rid,
  input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rlast,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  output logic                            unroutable_err
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;

  logic [IDX_W-1:0]     rr_ptr, win, win_reg, r_idx;
  logic                 have_win, grant, idx_ok;
  logic [CNT_W-1:0]     cnt [N_MASTERS];
  logic [N_MASTERS-1:0] eligible, inc, dec, cnt_nz;
  logic [MID_WIDTH-1:0]  sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_len;
  logic [2:0]            sel_size, sel_prot;
  logic [1:0]            sel_burst;
  logic                  sel_lock;
  logic [3:0]            sel_cache;

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      eligible[i] = s_axi_arvalid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
      cnt_nz[i]   = (cnt[i] != '0);
    end
  end

  // Round-robin search starting at rr_ptr; the first eligible master wins.
  always_comb begin
    int j;
    j        = 0;
    have_win = 1'b0;
    win      = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_MASTERS) j = j - N_MASTERS;
      if (!have_win && eligible[IDX_W'(j)]) begin
        have_win = 1'b1;
        win      = IDX_W'(j);
      end
    end
  end

  always_comb begin
    sel_id = '0; sel_addr = '0; sel_len = '0; sel_size = '0;
    sel_burst = '0; sel_lock = 1'b0; sel_cache = '0; sel_prot = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (win == IDX_W'(i)) begin
        sel_id    = s_axi_arid[i*MID_WIDTH +: MID_WIDTH];
        sel_addr  = s_axi_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len   = s_axi_arlen[i*8 +: 8];
        sel_size  = s_axi_arsize[i*3 +: 3];
        sel_burst = s_axi_arburst[i*2 +: 2];
        sel_lock  = s_axi_arlock[i];
        sel_cache = s_axi_arcache[i*4 +: 4];
        sel_prot  = s_axi_arprot[i*3 +: 3];
      end
    end
  end

  assign grant         = reset_n && (state == IDLE) && have_win;
  assign s_axi_arready = grant ? (N_MASTERS'(1) << win) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      win_reg       <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_arid    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
      m_axi_arlock  <= 1'b0;
      m_axi_arcache <= '0;
      m_axi_arprot  <= '0;
    end else begin
      case (state)
        IDLE: if (have_win) begin
          state         <= HOLD;
          win_reg       <= win;
          m_axi_arvalid <= 1'b1;
          m_axi_arid    <= {sel_id, win};
          m_axi_araddr  <= sel_addr;
          m_axi_arlen   <= sel_len;
          m_axi_arsize  <= sel_size;
          m_axi_arburst <= sel_burst;
          m_axi_arlock  <= sel_lock;
          m_axi_arcache <= sel_cache;
          m_axi_arprot  <= sel_prot;
        end
        HOLD: if (m_axi_arready) begin
          state         <= IDLE;
          m_axi_arvalid <= 1'b0;
          rr_ptr        <= (win_reg == IDX_W'(N_MASTERS - 1)) ? '0 : win_reg + IDX_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign r_idx  = m_axi_rid[IDX_W-1:0];
  assign idx_ok = (32'(r_idx) < N_MASTERS);

  // Beats with an index beyond N_MASTERS are accepted and dropped so the memory side never stalls.
  always_comb begin
    s_axi_rvalid = '0;
    m_axi_rready = 1'b1;
    if (idx_ok) begin
      s_axi_rvalid[r_idx] = m_axi_rvalid;
      m_axi_rready        = s_axi_rready[r_idx];
    end
  end

  assign s_axi_rid   = {N_MASTERS{m_axi_rid[ID_WIDTH-1:IDX_W]}};
  assign s_axi_rdata = {N_MASTERS{m_axi_rdata}};
  assign s_axi_rresp = {N_MASTERS{m_axi_rresp}};
  assign s_axi_rlast = {N_MASTERS{m_axi_rlast}};

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      inc[i] = grant && (win == IDX_W'(i));
      dec[i] = m_axi_rvalid && m_axi_rready && m_axi_rlast && idx_ok && (r_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_MASTERS; i++) cnt[i] <= '0;
      unroutable_err <= 1'b0;
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (inc[i] && !dec[i])
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (dec[i] && !inc[i] && cnt_nz[i])
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
      if (m_axi_rvalid && !idx_ok) unroutable_err <= 1'b1;
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) (dec & ~cnt_nz) == '0);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - self-checking bench for axi_read_arbiter
// Main instance: N=2, MAX_OUTSTANDING=2; second instance N=3 for unroutable indices.
module tb_axi_read_arbiter;
  localparam int N = 2, IDW = 13, MID = 12, AW = 64, DW = 64, MAXO = 2;
  localparam int N3 = 3, MID3 = 11;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*MID-1:0] s_arid;
  logic [N*AW-1:0]  s_araddr;
  logic [N*8-1:0]   s_arlen;
  logic [N*3-1:0]   s_arsize, s_arprot;
  logic [N*2-1:0]   s_arburst;
  logic [N-1:0]     s_arlock, s_arvalid, s_arready;
  logic [N*4-1:0]   s_arcache;
  logic [N*MID-1:0] s_rid;
  logic [N*DW-1:0]  s_rdata;
  logic [N*2-1:0]   s_rresp;
  logic [N-1:0]     s_rlast, s_rvalid, s_rready;
  logic [IDW-1:0]   m_arid, m_rid;
  logic [AW-1:0]    m_araddr;
  logic [7:0]       m_arlen;
  logic [2:0]       m_arsize, m_arprot;
  logic [1:0]       m_arburst, m_rresp;
  logic             m_arlock, m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, unroutable;
  logic [3:0]       m_arcache;
  logic [DW-1:0]    m_rdata;

  logic [N3*MID3-1:0] s3_arid, s3_rid;
  logic [N3*AW-1:0]   s3_araddr;
  logic [N3*8-1:0]    s3_arlen;
  logic [N3*3-1:0]    s3_arsize, s3_arprot;
  logic [N3*2-1:0]    s3_arburst, s3_rresp;
  logic [N3-1:0]      s3_arlock, s3_arvalid, s3_arready, s3_rlast, s3_rvalid, s3_rready;
  logic [N3*4-1:0]    s3_arcache;
  logic [N3*DW-1:0]   s3_rdata;
  logic [IDW-1:0]     m3_arid, m3_rid;
  logic [AW-1:0]      m3_araddr;
  logic [7:0]         m3_arlen;
  logic [2:0]         m3_arsize, m3_arprot;
  logic [1:0]         m3_arburst;
  logic               m3_arlock, m3_arvalid, m3_rvalid, m3_rready, unroutable3;
  logic [3:0]         m3_arcache;

  axi_read_arbiter #(.N_MASTERS(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen), .s_axi_arsize(s_arsize),
    .s_axi_arburst(s_arburst), .s_axi_arlock(s_arlock), .s_axi_arcache(s_arcache), .s_axi_arprot(s_arprot),
    .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
    .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
    .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
    .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize),
    .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock), .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot),
    .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready), .unroutable_err(unroutable)
  );

  axi_read_arbiter #(.N_MASTERS(N3), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .s_axi_arid(s3_arid), .s_axi_araddr(s3_araddr), .s_axi_arlen(s3_arlen), .s_axi_arsize(s3_arsize),
    .s_axi_arburst(s3_arburst), .s_axi_arlock(s3_arlock), .s_axi_arcache(s3_arcache), .s_axi_arprot(s3_arprot),
    .s_axi_arvalid(s3_arvalid), .s_axi_arready(s3_arready),
    .s_axi_rid(s3_rid), .s_axi_rdata(s3_rdata), .s_axi_rresp(s3_rresp), .s_axi_rlast(s3_rlast),
    .s_axi_rvalid(s3_rvalid), .s_axi_rready(s3_rready),
    .m_axi_arid(m3_arid), .m_axi_araddr(m3_araddr), .m_axi_arlen(m3_arlen), .m_axi_arsize(m3_arsize),
    .m_axi_arburst(m3_arburst), .m_axi_arlock(m3_arlock), .m_axi_arcache(m3_arcache), .m_axi_arprot(m3_arprot),
    .m_axi_arvalid(m3_arvalid), .m_axi_arready(1'b1),
    .m_axi_rid(m3_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(1'b0),
    .m_axi_rvalid(m3_rvalid), .m_axi_rready(m3_rready), .unroutable_err(unroutable3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [IDW-1:0] arid;
    logic [AW-1:0]  addr;
    logic [7:0]     len;
  } ar_exp_t;
  ar_exp_t q[$];
  ar_exp_t t_push, t_pop;

  // Scoreboard: upstream AR handshakes push the expected downstream request, downstream handshakes pop it.
  always begin
    @(negedge clk);
    #2;
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        if (s_arvalid[i] && s_arready[i]) begin
          t_push.arid = {s_arid[i*MID +: MID], 1'(i)};
          t_push.addr = s_araddr[i*AW +: AW];
          t_push.len  = s_arlen[i*8 +: 8];
          q.push_back(t_push);
        end
      end
      if (m_arvalid && m_arready) begin
        if (q.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          t_pop = q.pop_front();
          check("sb_arid", m_arid, t_pop.arid);
          check("sb_araddr", m_araddr, t_pop.addr);
          check("sb_arlen", m_arlen, t_pop.len);
          check("sb_arsize", m_arsize, 3'd3);
          check("sb_arburst", m_arburst, 2'b01);
        end
      end
    end
  end

  typedef struct {
    logic [IDW-1:0] rid;
    logic           rvalid;
    logic [1:0]     rready;
    logic [1:0]     exp_svalid;
    logic           exp_mready;
    logic [MID-1:0] exp_rid;
  } rvec_t;
  rvec_t tbl [6];
  logic [1:0] rr_exp [10];

  task automatic rburst(input int m, input logic [MID-1:0] mid, input int nbeats);
    int b;
    int guard;
    logic rr;
    b = 0; guard = 0; rr = 1'b0;
    while (b < nbeats && guard < 4 * nbeats + 4) begin
      @(negedge clk);
      m_rvalid = 1'b1;
      m_rid    = {mid, 1'(m)};
      m_rlast  = (b == nbeats - 1);
      s_rready = '0;
      s_rready[m] = rr;
      #1;
      check("r_svalid", s_rvalid, 2'b01 << m);
      check("r_mready", m_rready, rr);
      check("r_srid", s_rid[m*MID +: MID], mid);
      if (rr) b++;
      rr = !rr;
      guard++;
    end
    if (b < nbeats) check("r_timeout", b, nbeats);
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '0;
  endtask

  initial begin
    s_arid = '0; s_araddr = '0; s_arvalid = 2'b11; m_arready = 1'b0;
    s_arlen = {8'd4, 8'd1}; s_arsize = {2{3'd3}}; s_arburst = {2{2'b01}};
    s_arlock = '0; s_arcache = '0; s_arprot = '0; s_rready = '0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    s3_arid = '0; s3_araddr = '0; s3_arlen = '0; s3_arsize = '0; s3_arburst = '0;
    s3_arlock = '0; s3_arcache = '0; s3_arprot = '0; s3_arvalid = '0; s3_rready = '0;
    m3_rid = '0; m3_rvalid = 1'b0;

    tbl[0] = '{13'h0006, 1'b1, 2'b01, 2'b01, 1'b1, 12'h003};
    tbl[1] = '{13'h0006, 1'b1, 2'b10, 2'b01, 1'b0, 12'h003};
    tbl[2] = '{13'h1579, 1'b1, 2'b10, 2'b10, 1'b1, 12'hABC};
    tbl[3] = '{13'h1579, 1'b0, 2'b11, 2'b00, 1'b1, 12'hABC};
    tbl[4] = '{13'h0003, 1'b1, 2'b01, 2'b10, 1'b0, 12'h001};
    tbl[5] = '{13'h1FFE, 1'b0, 2'b00, 2'b00, 1'b0, 12'hFFF};
    rr_exp = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};

    // Reset state with both masters requesting
    repeat (2) @(negedge clk);
    #1;
    check("rst_arready", s_arready, 2'b00);
    check("rst_arvalid", m_arvalid, 1'b0);
    check("rst_arid", m_arid, 13'd0);
    check("rst_araddr", m_araddr, 64'd0);
    check("rst_unroutable", unroutable, 1'b0);
    @(negedge clk);
    reset_n = 1'b1; s_arvalid = 2'b00;

    // Combinational R routing table (no rlast, so counters are untouched)
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      m_rid = tbl[v].rid; m_rvalid = tbl[v].rvalid; s_rready = tbl[v].rready;
      m_rdata = 64'hDEAD_BEEF_0000_0000 + 64'(v);
      #1;
      check("tbl_svalid", s_rvalid, tbl[v].exp_svalid);
      check("tbl_mready", m_rready, tbl[v].exp_mready);
      check("tbl_rid0", s_rid[0 +: MID], tbl[v].exp_rid);
      check("tbl_rid1", s_rid[MID +: MID], tbl[v].exp_rid);
      check("tbl_rdata1", s_rdata[DW +: DW], 64'hDEAD_BEEF_0000_0000 + 64'(v));
    end
    @(negedge clk);
    m_rvalid = 1'b0; s_rready = '0;

    // Single request from master 0
    @(negedge clk);
    s_arid[0 +: MID] = 12'd5; s_araddr[0 +: AW] = 64'h1000; s_arvalid = 2'b01; m_arready = 1'b1;
    #1;
    check("single_arready", s_arready, 2'b01);
    @(negedge clk);
    s_arvalid = 2'b00;
    #1;
    check("single_marvalid", m_arvalid, 1'b1);
    check("single_marid", m_arid, 13'h00A);
    check("single_maraddr", m_araddr, 64'h1000);
    check("single_hold_arready", s_arready, 2'b00);
    @(negedge clk);
    #1;
    check("single_idle", m_arvalid, 1'b0);
    rburst(0, 12'd5, 1);

    // Round robin from rr_ptr=1 until both masters reach the outstanding limit
    @(negedge clk);
    s_araddr[0 +: AW] = 64'h2000; s_araddr[AW +: AW] = 64'h3000; s_arid[MID +: MID] = 12'd9;
    s_arvalid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("rr_grant", s_arready, rr_exp[c]);
    end
    s_arvalid = 2'b00;

    // One rlast for master 1 frees a slot; master 1 wins next, then both are full again
    rburst(1, 12'd9, 1);
    @(negedge clk);
    s_arvalid = 2'b11;
    #1;
    check("lim_grant1", s_arready, 2'b10);
    @(negedge clk);
    #1;
    check("lim_hold", s_arready, 2'b00);
    @(negedge clk);
    #1;
    check("lim_full", s_arready, 2'b00);
    s_arvalid = 2'b00;

    // 4-beat burst to master 1 with toggling ready, then backpressure in HOLD
    rburst(1, 12'd7, 4);
    rburst(0, 12'd2, 1);
    @(negedge clk);
    s_arid[0 +: MID] = 12'h123; s_araddr[0 +: AW] = 64'h4000; s_arvalid = 2'b01; m_arready = 1'b0;
    #1;
    check("bp_grant0", s_arready, 2'b01);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s_araddr[AW +: AW] = 64'h5000; s_arvalid = 2'b11;
      #1;
      check("bp_marvalid", m_arvalid, 1'b1);
      check("bp_maraddr", m_araddr, 64'h4000);
      check("bp_marid", m_arid, 13'h0246);
      check("bp_arready", s_arready, 2'b00);
    end
    @(negedge clk);
    m_arready = 1'b1;
    #1;
    check("bp_release", m_arvalid, 1'b1);
    @(negedge clk);
    #1;
    check("bp_next_grant", s_arready, 2'b10);
    @(negedge clk);
    s_arvalid = 2'b00;
    #1;
    check("bp_next_addr", m_araddr, 64'h5000);
    @(negedge clk);
    #1;
    check("bp_done", m_arvalid, 1'b0);
    check("sb_empty", q.size(), 0);

    // N=3 instance: valid index 2 routes, index 3 is dropped and latches the error
    @(negedge clk);
    m3_rid = {11'h22, 2'd2}; m3_rvalid = 1'b1; s3_rready = 3'b100;
    #1;
    check("n3_svalid", s3_rvalid, 3'b100);
    check("n3_mready", m3_rready, 1'b1);
    check("n3_rid2", s3_rid[2*MID3 +: MID3], 11'h22);
    @(negedge clk);
    m3_rid = {11'h55, 2'd3}; s3_rready = 3'b000;
    #1;
    check("unr_mready", m3_rready, 1'b1);
    check("unr_svalid", s3_rvalid, 3'b000);
    check("unr_before", unroutable3, 1'b0);
    @(negedge clk);
    m3_rvalid = 1'b0;
    #1;
    check("unr_set", unroutable3, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("unr_sticky", unroutable3, 1'b1);
    check("main_unroutable", unroutable, 1'b0);
    reset_n = 1'b0;
    #1;
    check("unr_cleared", unroutable3, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
